// File: rtl/proc_sched_pkg.sv
// Shared definitions for the ready-process scheduler: command bit indices,
// status bit positions, timer clear-ready opcode and FSM state encodings.
package proc_sched_pkg;

  localparam int CTRL_PRIO  = 0;
  localparam int CTRL_EN    = 1;
  localparam int CTRL_DIS   = 2;
  localparam int CTRL_START = 3;
  localparam int CTRL_LAST  = 4;

  localparam int ST_VALID = 31;
  localparam int ST_BUSY  = 30;
  localparam int ST_FOUND = 29;

  localparam logic [7:0] TMR_CLR_RDY = 8'h08;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  function automatic logic [31:0] clr_cmd(input logic [4:0] sel);
    return {16'h0, 3'b0, sel, TMR_CLR_RDY};
  endfunction

endpackage

// File: rtl/proc_sched.sv
// Ready-process scheduler: snapshots enabled ready bits, scans one candidate per
// cycle for the highest priority (round-robin after last), then clears its ready bit.
module proc_sched
  import proc_sched_pkg::*;
#(
  parameter int NPROC = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stb,
  input  logic             we,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             ack,
  input  logic [NPROC-1:0] proc_rdy,
  output logic             clr_stb,
  output logic [31:0]      clr_data
);

  state_t state, state_nxt;

  logic                  wr, rd;
  logic [7:0]            ctrl;
  logic [4:0]            which;
  logic [1:0]            cfg_prio;
  logic [NPROC-1:0][1:0] prio, prio_nxt, snap_prio;
  logic [NPROC-1:0]      en, en_nxt, snap_rdy;
  logic [4:0]            last, k, cand, best;
  logic [1:0]            best_prio;
  logic                  best_valid, valid, found, busy;
  logic                  start_acc, take, scan_done;
  logic                  unused_ok;

  assign wr        = stb & we;
  assign rd        = stb & ~we;
  assign ctrl      = data_in[7:0];
  assign which     = data_in[12:8];
  assign cfg_prio  = data_in[17:16];
  assign unused_ok = ^{data_in[31:18], data_in[15:13], ctrl[7:5]};
  assign ack       = stb;

  assign start_acc = wr & ctrl[CTRL_START] & (state == S_IDLE);

  // 5-bit wrap gives the round-robin order starting just after last.
  assign cand      = last + 5'd1 + k;
  assign take      = snap_rdy[cand] & (~best_valid | (snap_prio[cand] > best_prio));
  assign scan_done = (k == 5'd31) | (take & (snap_prio[cand] == 2'd3));

  always_comb begin
    prio_nxt = prio;
    en_nxt   = en;
    if (wr) begin
      if (ctrl[CTRL_PRIO]) prio_nxt[which] = cfg_prio;
      if (ctrl[CTRL_DIS])     en_nxt[which] = 1'b0;
      else if (ctrl[CTRL_EN]) en_nxt[which] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_acc) state_nxt = S_SCAN;
      S_SCAN:  if (scan_done) state_nxt = (best_valid | take) ? S_CLEAR : S_IDLE;
      S_CLEAR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    clr_stb  = (state == S_CLEAR);
    clr_data = clr_stb ? clr_cmd(best) : 32'h0;
    data_out = 32'h0;
    if (rd) begin
      data_out[ST_VALID] = valid;
      data_out[ST_BUSY]  = busy;
      data_out[ST_FOUND] = found;
      if (found) begin
        data_out[9:8] = best_prio;
        data_out[4:0] = best;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio       <= '0;
      en         <= '0;
      last       <= 5'd31;
      snap_rdy   <= '0;
      snap_prio  <= '0;
      k          <= 5'd0;
      best       <= 5'd0;
      best_prio  <= 2'd0;
      best_valid <= 1'b0;
      valid      <= 1'b0;
      found      <= 1'b0;
    end else begin
      prio <= prio_nxt;
      en   <= en_nxt;
      if (rd) valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr & ctrl[CTRL_LAST]) last <= which;
          if (start_acc) begin
            snap_rdy   <= proc_rdy & en_nxt;
            snap_prio  <= prio_nxt;
            k          <= 5'd0;
            best_valid <= 1'b0;
            valid      <= 1'b0;
          end
        end
        S_SCAN: begin
          if (take) begin
            best       <= cand;
            best_prio  <= snap_prio[cand];
            best_valid <= 1'b1;
          end
          k <= k + 5'd1;
          if (scan_done & ~(best_valid | take)) begin
            found <= 1'b0;
            valid <= 1'b1;
          end
        end
        S_CLEAR: begin
          last  <= best;
          found <= 1'b1;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sched.sv
// Directed bench for proc_sched: table of config writes and scans with
// hand-computed timing/status, plus a reset-during-scan sequence.
module tb_proc_sched;

  logic        clk = 1'b0;
  logic        rst, stb, we, ack, clr_stb;
  logic [31:0] data_in, data_out, proc_rdy, clr_data;

  int checks   = 0;
  int failures = 0;

  proc_sched dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .proc_rdy (proc_rdy),
    .clr_stb  (clr_stb),
    .clr_data (clr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 = config write, 1 = scan
    logic [31:0] cmd;
    logic [31:0] rdy;
    int          clr_j;  // edge offset of clr_stb from start, -1 = none
    logic [31:0] clr_d;
    int          vld_j;  // first edge offset where a read sees valid
    logic [31:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] cmd);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; data_in = cmd;
    @(negedge clk);
    stb = 1'b0; we = 1'b0; data_in = 32'h0;
  endtask

  task automatic scan(input logic [31:0] cmd, output int clr_j, output logic [31:0] clr_d,
                      output int nclr, output int vld_j, output logic [31:0] st);
    clr_j = -1; clr_d = 32'h0; nclr = 0; vld_j = -1; st = 32'h0;
    @(negedge clk);
    stb = 1'b1; we = 1'b1; data_in = cmd;
    for (int j = 0; j < 60 && vld_j < 0; j++) begin
      @(negedge clk);
      if (clr_stb) begin
        nclr++;
        if (clr_j < 0) begin
          clr_j = j + 1;
          clr_d = clr_data;
        end
      end
      stb = 1'b1; we = 1'b0; data_in = 32'h0;
      #1;
      if (data_out[31]) begin
        vld_j = j + 1;
        st    = data_out;
      end
    end
    @(negedge clk);
    if (clr_stb) nclr++;
    stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    int          cj, nc, vj, idle_clr;
    logic [31:0] cd, st;

    tbl.push_back('{1, 32'h0000_0008, 32'hFFFF_FFFF, -1, 32'h0,         33, 32'h8000_0000});
    tbl.push_back('{0, 32'h0001_0303, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0001_0703, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0001_1403, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h0000_0008, 32'hFFFF_FFFF, 33, 32'h0000_0308, 34, 32'hA000_0103});
    tbl.push_back('{1, 32'h0000_0008, 32'hFFFF_FFFF, 33, 32'h0000_0708, 34, 32'hA000_0107});
    tbl.push_back('{1, 32'h0000_0008, 32'hFFFF_FFFF, 33, 32'h0000_1408, 34, 32'hA000_0114});
    tbl.push_back('{0, 32'h0000_0304, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0000_0704, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0000_1404, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0001_0203, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0002_0903, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h0000_0008, 32'hFFFF_FFFF, 33, 32'h0000_0908, 34, 32'hA000_0209});
    tbl.push_back('{0, 32'h0000_0204, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0000_0904, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0003_0503, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0000_0410, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h0000_0008, 32'hFFFF_FFFF, 2,  32'h0000_0508, 3,  32'hA000_0305});
    tbl.push_back('{0, 32'h0000_0504, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0000_0103, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{0, 32'h0000_1E10, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h0000_0008, 32'h0000_0002, 33, 32'h0000_0108, 34, 32'hA000_0001});
    // disable wins over enable in the same write
    tbl.push_back('{0, 32'h0000_0106, 32'h0, 0, 32'h0, 0, 32'h0});
    tbl.push_back('{1, 32'h0000_0008, 32'h0000_0002, -1, 32'h0,         33, 32'h8000_0000});

    rst = 1'b0; stb = 1'b0; we = 1'b0; data_in = 32'h0; proc_rdy = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_clr_stb", {31'h0, clr_stb}, 32'h0);
    chk("reset_clr_data", clr_data, 32'h0);
    chk("idle_data_out", data_out, 32'h0);
    stb = 1'b1; we = 1'b0; #1;
    chk("reset_status", data_out, 32'h0);
    chk("ack_follows_stb", {31'h0, ack}, 32'h1);
    @(negedge clk);
    stb = 1'b0; #1;
    chk("ack_low", {31'h0, ack}, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].kind == 0) begin
        wr(tbl[i].cmd);
      end else begin
        proc_rdy = tbl[i].rdy;
        scan(tbl[i].cmd, cj, cd, nc, vj, st);
        chk($sformatf("v%0d_clr_edge", i), cj, tbl[i].clr_j);
        chk($sformatf("v%0d_clr_data", i), cd, tbl[i].clr_d);
        chk($sformatf("v%0d_clr_count", i), nc, (tbl[i].clr_j < 0) ? 0 : 1);
        chk($sformatf("v%0d_valid_edge", i), vj, tbl[i].vld_j);
        chk($sformatf("v%0d_status", i), st, tbl[i].st);
        chk($sformatf("v%0d_clr_data_idle", i), clr_data, 32'h0);
      end
    end

    // Reset asserted so that edge E0+10 lands mid-scan.
    wr(32'h0000_0103);
    proc_rdy = 32'hFFFF_FFFF;
    idle_clr = 0;
    @(negedge clk);
    stb = 1'b1; we = 1'b1; data_in = 32'h0000_0008;
    @(negedge clk);
    stb = 1'b0; we = 1'b0; data_in = 32'h0;
    for (int j = 1; j < 10; j++) begin
      @(negedge clk);
      if (clr_stb) idle_clr++;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (clr_stb) idle_clr++;
    end
    chk("rst_mid_scan_no_clr", idle_clr, 0);
    stb = 1'b1; we = 1'b0; #1;
    chk("rst_mid_scan_status", data_out, 32'h0);
    @(negedge clk);
    stb = 1'b0;

    // Enables cleared by reset; last back to 31 so process 0 comes first.
    wr(32'h0000_0003);
    wr(32'h0000_0103);
    scan(32'h0000_0008, cj, cd, nc, vj, st);
    chk("post_rst_clr_edge", cj, 33);
    chk("post_rst_clr_data", cd, 32'h0000_0008);
    chk("post_rst_status", st, 32'hA000_0000);
    chk("post_rst_valid_edge", vj, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
